debug_command_parser: RTL and testbench

- Byte-stream framer/sequencer that sits directly downstream of the debug UART receiver in the debug peripheral.
- Assembles fixed 10-byte command frames from received bytes, validates checksum and opcode, and presents one decoded command at a time on a valid/ready handshake.
- The consumer is the debug command executor (memory access, halt/resume/reset of the CPU core).
- Enforces an inter-byte timeout so a truncated frame cannot desynchronise the stream.

---
 rtl/debug_command_parser.sv | 176 +++++++++++++++++
 tb/tb_debug_command_parser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_command_parser.sv
// Frames 10-byte debug commands from the UART byte stream, validates checksum/opcode
// and presents one decoded command at a time on a valid/ready handshake.
module debug_command_parser #(
   parameter int unsigned TIMEOUT_CLOCKS = 100000
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Cmd_Valid,
   input  logic        i_Cmd_Ready,
   output logic [7:0]  o_Cmd_Opcode,
   output logic [31:0] o_Cmd_Addr,
   output logic [31:0] o_Cmd_Data,
   output logic        o_Err_Checksum,
   output logic        o_Err_Opcode,
   output logic        o_Err_Timeout,
   output logic        o_Err_Overrun
);

   localparam int unsigned CNT_W  = (TIMEOUT_CLOCKS > 2) ? $clog2(TIMEOUT_CLOCKS) : 1;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {s_IDLE, s_ADDR, s_DATA, s_CHECK, s_ISSUE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [BYTE_W-1:0]   xor_q, xor_d;
   logic [BYTE_W-1:0]   op_q, op_d;
   logic [WORD_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                valid_d;
   logic [BYTE_W-1:0]   cmd_op_d;
   logic [WORD_W-1:0]   cmd_addr_d, cmd_data_d;
   logic                err_chk_d, err_opc_d, err_to_d, err_ovr_d;

   logic                counting, expired, op_known, accept;

   always_comb begin
      counting = (state_q == s_ADDR) || (state_q == s_DATA) || (state_q == s_CHECK);
      expired  = counting && !i_Rx_DV && (cnt_q == CNT_W'(TIMEOUT_CLOCKS - 1));
      op_known = (op_q >= 8'h01) && (op_q <= 8'h05);
      accept   = o_Cmd_Valid && i_Cmd_Ready;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      xor_d      = xor_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = '0;
      valid_d    = o_Cmd_Valid;
      cmd_op_d   = o_Cmd_Opcode;
      cmd_addr_d = o_Cmd_Addr;
      cmd_data_d = o_Cmd_Data;
      err_chk_d  = 1'b0;
      err_opc_d  = 1'b0;
      err_to_d   = 1'b0;
      err_ovr_d  = 1'b0;

      if (counting && !i_Rx_DV) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         s_IDLE: begin
            if (i_Rx_DV) begin
               op_d    = i_Rx_Byte;
               xor_d   = i_Rx_Byte;
               idx_d   = 2'd0;
               state_d = s_ADDR;
            end
         end
         s_ADDR: begin
            if (i_Rx_DV) begin
               addr_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
               xor_d = xor_q ^ i_Rx_Byte;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = s_DATA;
            end else if (expired) begin
               err_to_d = 1'b1;
               state_d  = s_IDLE;
            end
         end
         s_DATA: begin
            if (i_Rx_DV) begin
               data_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
               xor_d = xor_q ^ i_Rx_Byte;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = s_CHECK;
            end else if (expired) begin
               err_to_d = 1'b1;
               state_d  = s_IDLE;
            end
         end
         s_CHECK: begin
            if (i_Rx_DV) begin
               state_d = s_IDLE;
               if (i_Rx_Byte != xor_q) begin
                  err_chk_d = 1'b1;
               end else if (!op_known) begin
                  err_opc_d = 1'b1;
               end else begin
                  valid_d    = 1'b1;
                  cmd_op_d   = op_q;
                  cmd_addr_d = addr_q;
                  cmd_data_d = data_q;
                  state_d    = s_ISSUE;
               end
            end else if (expired) begin
               err_to_d = 1'b1;
               state_d  = s_IDLE;
            end
         end
         s_ISSUE: begin
            // A byte in the accept cycle starts the next frame instead of overrunning
            if (accept) begin
               valid_d = 1'b0;
               state_d = s_IDLE;
               if (i_Rx_DV) begin
                  op_d    = i_Rx_Byte;
                  xor_d   = i_Rx_Byte;
                  idx_d   = 2'd0;
                  state_d = s_ADDR;
               end
            end else if (i_Rx_DV) begin
               err_ovr_d = 1'b1;
            end
         end
         default: state_d = s_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q        <= s_IDLE;
         idx_q          <= '0;
         xor_q          <= '0;
         op_q           <= '0;
         addr_q         <= '0;
         data_q         <= '0;
         cnt_q          <= '0;
         o_Cmd_Valid    <= 1'b0;
         o_Cmd_Opcode   <= '0;
         o_Cmd_Addr     <= '0;
         o_Cmd_Data     <= '0;
         o_Err_Checksum <= 1'b0;
         o_Err_Opcode   <= 1'b0;
         o_Err_Timeout  <= 1'b0;
         o_Err_Overrun  <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         xor_q          <= xor_d;
         op_q           <= op_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         cnt_q          <= cnt_d;
         o_Cmd_Valid    <= valid_d;
         o_Cmd_Opcode   <= cmd_op_d;
         o_Cmd_Addr     <= cmd_addr_d;
         o_Cmd_Data     <= cmd_data_d;
         o_Err_Checksum <= err_chk_d;
         o_Err_Opcode   <= err_opc_d;
         o_Err_Timeout  <= err_to_d;
         o_Err_Overrun  <= err_ovr_d;
      end
   end

endmodule

// File: tb/tb_debug_command_parser.sv
// Scoreboard bench for debug_command_parser: a frame-level reference model predicts
// commands and error pulses; a negedge monitor compares whatever the DUT presents.
module tb_debug_command_parser;

   localparam int unsigned TO = 16;
   localparam int E_CHK = 1;
   localparam int E_OPC = 2;
   localparam int E_TMO = 3;
   localparam int E_OVR = 4;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } cmd_t;
   typedef logic [7:0] frame_t [10];

   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b1;
   logic        i_Rx_DV = 1'b0;
   logic [7:0]  i_Rx_Byte = 8'h00;
   logic        i_Cmd_Ready = 1'b0;
   logic        o_Cmd_Valid;
   logic [7:0]  o_Cmd_Opcode;
   logic [31:0] o_Cmd_Addr;
   logic [31:0] o_Cmd_Data;
   logic        o_Err_Checksum, o_Err_Opcode, o_Err_Timeout, o_Err_Overrun;

   always #5 i_Clock = ~i_Clock;

   debug_command_parser #(.TIMEOUT_CLOCKS(TO)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
      .o_Cmd_Valid(o_Cmd_Valid), .i_Cmd_Ready(i_Cmd_Ready), .o_Cmd_Opcode(o_Cmd_Opcode),
      .o_Cmd_Addr(o_Cmd_Addr), .o_Cmd_Data(o_Cmd_Data), .o_Err_Checksum(o_Err_Checksum),
      .o_Err_Opcode(o_Err_Opcode), .o_Err_Timeout(o_Err_Timeout), .o_Err_Overrun(o_Err_Overrun)
   );

   int   errors = 0;
   int   checks = 0;
   cmd_t cmd_q[$];
   int   err_q[$];

   // Reference model state: bytes of the frame in progress, pending command, idle clocks
   logic [7:0] fb[$];
   bit         pending = 1'b0;
   int         idle = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic frame_t mk(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input bit bad);
      frame_t f;
      logic [7:0] x;
      f[0] = op;
      for (int i = 0; i < 4; i++) begin
         f[1+i] = addr[8*i +: 8];
         f[5+i] = data[8*i +: 8];
      end
      x = 8'h00;
      for (int i = 0; i < 9; i++) x = x ^ f[i];
      f[9] = bad ? ~x : x;
      return f;
   endfunction

   // Applies the rules of the byte stream for one clock edge
   task automatic model_edge();
      logic [7:0] x;
      cmd_t c;
      if (i_Reset) begin
         fb.delete();
         pending = 1'b0;
         idle = 0;
         cmd_q.delete();
         return;
      end
      if (pending) begin
         if (i_Cmd_Ready) begin
            pending = 1'b0;
            if (i_Rx_DV) begin
               fb.push_back(i_Rx_Byte);
               idle = 0;
            end
         end else if (i_Rx_DV) begin
            err_q.push_back(E_OVR);
         end
      end else if (i_Rx_DV) begin
         fb.push_back(i_Rx_Byte);
         idle = 0;
         if (fb.size() == 10) begin
            x = 8'h00;
            for (int i = 0; i < 9; i++) x = x ^ fb[i];
            if (fb[9] != x) err_q.push_back(E_CHK);
            else if (fb[0] < 8'h01 || fb[0] > 8'h05) err_q.push_back(E_OPC);
            else begin
               c.op   = fb[0];
               c.addr = {fb[4], fb[3], fb[2], fb[1]};
               c.data = {fb[8], fb[7], fb[6], fb[5]};
               cmd_q.push_back(c);
               pending = 1'b1;
            end
            fb.delete();
         end
      end else if (fb.size() != 0) begin
         idle++;
         if (idle == int'(TO)) begin
            err_q.push_back(E_TMO);
            fb.delete();
         end
      end
   endtask

   task automatic cyc(input bit dv, input logic [7:0] b, input bit rdy);
      i_Rx_DV = dv;
      i_Rx_Byte = b;
      i_Cmd_Ready = rdy;
      @(posedge i_Clock);
      model_edge();
      #1;
   endtask

   task automatic idle_n(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
   endtask

   task automatic send(input frame_t f, input int first, input int last, input bit rdy);
      for (int i = first; i <= last; i++) cyc(1'b1, f[i], rdy);
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      i_Reset = 1'b0;
      check("rst_valid", 64'(o_Cmd_Valid), 64'(0));
      check("rst_fields", 64'(o_Cmd_Opcode) | 64'(o_Cmd_Addr) | 64'(o_Cmd_Data), 64'(0));
      check("rst_errs", 64'({o_Err_Checksum, o_Err_Opcode, o_Err_Timeout, o_Err_Overrun}), 64'(0));
   endtask

   task automatic mon_err(input int code);
      int e;
      checks++;
      if (err_q.size() == 0) begin
         errors++;
         $display("FAIL err_pulse: got unexpected code %0d expected none at %0t", code, $time);
      end else begin
         e = err_q.pop_front();
         if (e != code) begin
            errors++;
            $display("FAIL err_pulse: got code %0d expected %0d at %0t", code, e, $time);
         end
      end
   endtask

   // Monitor: error pulses in order, command fields every cycle valid is high, pop on accept
   always @(negedge i_Clock) begin
      if (o_Err_Checksum === 1'b1) mon_err(E_CHK);
      if (o_Err_Opcode === 1'b1)   mon_err(E_OPC);
      if (o_Err_Timeout === 1'b1)  mon_err(E_TMO);
      if (o_Err_Overrun === 1'b1)  mon_err(E_OVR);
      if (o_Cmd_Valid === 1'b1) begin
         if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_valid: got unexpected command op=%0h expected none at %0t",
                     o_Cmd_Opcode, $time);
         end else begin
            check("cmd_op", 64'(o_Cmd_Opcode), 64'(cmd_q[0].op));
            check("cmd_addr", 64'(o_Cmd_Addr), 64'(cmd_q[0].addr));
            check("cmd_data", 64'(o_Cmd_Data), 64'(cmd_q[0].data));
            if (i_Cmd_Ready === 1'b1) void'(cmd_q.pop_front());
         end
      end
   end

   initial begin
      frame_t f, g;
      int     n, gap;
      logic [7:0] op;

      idle_n(2, 1'b0);
      do_reset();

      // Write frame, ready held high, one-clock latency
      f = mk(8'h02, 32'h12345678, 32'hDEADBEEF, 1'b0);
      send(f, 0, 9, 1'b1);
      check("write_latency", 64'(o_Cmd_Valid), 64'(1));
      idle_n(3, 1'b1);

      // Bad checksum then a good frame
      f = mk(8'h02, 32'h12345678, 32'hDEADBEEF, 1'b1);
      send(f, 0, 9, 1'b1);
      check("chk_pulse", 64'(o_Err_Checksum), 64'(1));
      check("chk_novalid", 64'(o_Cmd_Valid), 64'(0));
      idle_n(2, 1'b1);
      f = mk(8'h04, 32'hA5A5_0001, 32'h0000_FFFF, 1'b0);
      send(f, 0, 9, 1'b1);
      idle_n(2, 1'b1);

      // Unknown opcode, and checksum priority over opcode
      f = mk(8'h7F, 32'h1, 32'h2, 1'b0);
      send(f, 0, 9, 1'b1);
      check("opc_pulse", 64'(o_Err_Opcode), 64'(1));
      f = mk(8'h7F, 32'h1, 32'h2, 1'b1);
      send(f, 0, 9, 1'b1);
      check("prio_opc", 64'(o_Err_Opcode), 64'(0));
      check("prio_chk", 64'(o_Err_Checksum), 64'(1));
      idle_n(2, 1'b1);

      // Timeout boundary: 16 idle clocks expire, 15 do not
      f = mk(8'h01, 32'hCAFE_0000, 32'h1234_5678, 1'b0);
      send(f, 0, 3, 1'b1);
      idle_n(int'(TO) - 1, 1'b1);
      check("to_early", 64'(o_Err_Timeout), 64'(0));
      idle_n(1, 1'b1);
      check("to_pulse", 64'(o_Err_Timeout), 64'(1));
      send(f, 0, 9, 1'b1);
      idle_n(1, 1'b1);
      send(f, 0, 3, 1'b1);
      idle_n(int'(TO) - 1, 1'b1);
      send(f, 4, 9, 1'b1);
      check("to_gap_ok", 64'(o_Cmd_Valid), 64'(1));
      idle_n(2, 1'b1);

      // Overrun while pending, then accept coincident with the next frame's first byte
      f = mk(8'h03, 32'h0, 32'h0, 1'b0);
      send(f, 0, 9, 1'b0);
      idle_n(2, 1'b0);
      cyc(1'b1, 8'hAA, 1'b0);
      check("ovr_pulse", 64'(o_Err_Overrun), 64'(1));
      check("ovr_valid", 64'(o_Cmd_Valid), 64'(1));
      idle_n(1, 1'b0);
      g = mk(8'h05, 32'h0BAD_F00D, 32'h7777_8888, 1'b0);
      send(g, 0, 0, 1'b1);
      check("acc_drop", 64'(o_Cmd_Valid), 64'(0));
      check("acc_no_ovr", 64'(o_Err_Overrun), 64'(0));
      send(g, 1, 9, 1'b1);
      check("acc_next", 64'(o_Cmd_Valid), 64'(1));
      idle_n(2, 1'b1);

      // Reset mid-frame and with a pending command
      send(f, 0, 5, 1'b1);
      do_reset();
      send(g, 0, 9, 1'b0);
      idle_n(1, 1'b0);
      do_reset();
      send(g, 0, 9, 1'b1);
      idle_n(2, 1'b1);

      // Randomized frames, gaps, ready and occasional truncation/reset
      for (int k = 0; k < 150; k++) begin
         op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 5));
         f = mk(op, $urandom, $urandom, $urandom_range(0, 7) == 0);
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 9) : 10;
         for (int i = 0; i < n; i++) begin
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(int'(TO) - 1, int'(TO))
                                               : $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) cyc(1'b0, 8'h00, $urandom_range(0, 3) != 0);
            cyc(1'b1, f[i], $urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 39) == 0) do_reset();
      end

      idle_n(int'(TO) + 4, 1'b1);
      check("err_q_drained", 64'(err_q.size()), 64'(0));
      check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
